// File: rtl/pipe_out_serializer_pkg.sv
// Shared types and helpers for the transmit-side pipe framer.
// Defines the framer states, the header word layout and the per-method length lookup.
package pipe_ser_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } ser_state_t;

    typedef struct packed {
        logic [15:0] method;
        logic [15:0] len;
    } ser_hdr_t;

    localparam int MAX_METHODS = 64;
    localparam int TABLE_WIDTH = 4 * MAX_METHODS;

    // Methods beyond the table report zero words; callers reject them before use.
    function automatic logic [3:0] method_words(input logic [TABLE_WIDTH-1:0] table_bits,
                                                input logic [15:0] method);
        logic [3:0] words;
        words = 4'd0;
        if (int'(method) < MAX_METHODS) begin
            words = table_bits[int'(method) * 4 +: 4];
        end
        return words;
    endfunction

endpackage

// File: rtl/pipe_out_serializer_if.sv
// Enqueue-style handshake bundle: ENA qualifies the value, RDY says the sink can take it.
interface pipe_out_serializer_if #(
    parameter int WIDTH = 32
);

    logic             enq__ENA;
    logic [WIDTH-1:0] enq_v;
    logic             enq__RDY;

    modport master (
        output enq__ENA,
        output enq_v,
        input  enq__RDY
    );

    modport slave (
        input  enq__ENA,
        input  enq_v,
        output enq__RDY
    );

endinterface

// File: rtl/pipe_out_serializer.sv
// Frames 144-bit pipe messages into a header word plus len payload words on a 32-bit stream.
// Unknown methods are swallowed and counted in a saturating drop counter.
module pipe_out_serializer
    import pipe_ser_pkg::*;
#(
    parameter int                       METHOD_WIDTH = 16,
    parameter int                       DATA_WIDTH   = 128,
    parameter int                       WORD_WIDTH   = 32,
    parameter int                       NUM_METHODS  = 1,
    parameter logic [4*NUM_METHODS-1:0] METHOD_WORDS = 4'd1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    pipe_out_serializer_if.slave  pipe,
    pipe_out_serializer_if.master out,
    output logic [15:0]          drop_count
);

    localparam int NUM_WORDS = DATA_WIDTH / WORD_WIDTH;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [TABLE_WIDTH-1:0] LEN_TABLE = TABLE_WIDTH'(METHOD_WORDS);

    ser_state_t              state;
    logic [DATA_WIDTH-1:0]   payload_q;
    logic [3:0]              len_q;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_next;
    logic [WORD_WIDTH-1:0]   word_q;
    logic                    up_q;

    logic [METHOD_WIDTH-1:0] in_method;
    logic [DATA_WIDTH-1:0]   in_payload;
    logic [3:0]              in_len;
    logic                    method_known;
    ser_hdr_t                new_hdr;
    logic                    last_word;
    logic                    out_xfer;
    logic                    accept;
    logic                    take;
    logic                    drop;

    assign in_method    = pipe.enq_v[DATA_WIDTH +: METHOD_WIDTH];
    assign in_payload   = pipe.enq_v[DATA_WIDTH-1:0];
    assign in_len       = method_words(LEN_TABLE, 16'(in_method));
    assign method_known = (int'(in_method) < NUM_METHODS);
    assign new_hdr      = {16'(in_method), 12'd0, in_len};

    assign idx_next  = idx + IDX_W'(1);
    assign last_word = (state == DATA) && (4'(idx) == (len_q - 4'd1));

    assign out.enq__ENA = out.enq__RDY && (state != IDLE);
    assign out.enq_v    = word_q;
    assign out_xfer     = out.enq__ENA;

    // A new message may overlap the final payload transfer so frames run back to back.
    assign pipe.enq__RDY = up_q && ((state == IDLE) || (last_word && out.enq__RDY));
    assign accept        = pipe.enq__ENA && pipe.enq__RDY;
    assign take          = accept && method_known;
    assign drop          = accept && !method_known;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            payload_q  <= '0;
            len_q      <= 4'd0;
            idx        <= '0;
            word_q     <= '0;
            up_q       <= 1'b0;
            drop_count <= 16'd0;
        end else begin
            up_q <= 1'b1;

            if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (take) begin
                        payload_q <= in_payload;
                        len_q     <= in_len;
                        word_q    <= WORD_WIDTH'(new_hdr);
                        state     <= HDR;
                    end
                end

                HDR: begin
                    if (out_xfer) begin
                        idx    <= '0;
                        word_q <= payload_q[0 +: WORD_WIDTH];
                        state  <= DATA;
                    end
                end

                DATA: begin
                    if (out_xfer) begin
                        if (last_word) begin
                            idx <= '0;
                            if (take) begin
                                payload_q <= in_payload;
                                len_q     <= in_len;
                                word_q    <= WORD_WIDTH'(new_hdr);
                                state     <= HDR;
                            end else begin
                                word_q <= '0;
                                state  <= IDLE;
                            end
                        end else begin
                            idx    <= idx_next;
                            word_q <= payload_q[int'(idx_next) * WORD_WIDTH +: WORD_WIDTH];
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_out_serializer.sv
// Bench for pipe_out_serializer: a queue-of-expected-words model is compared every cycle,
// with directed frames pinned by literal values and a randomized traffic phase.
module tb_pipe_out_serializer;

    localparam int NUM_METHODS = 3;

    logic        CLK  = 1'b0;
    logic        nRST = 1'b1;
    logic [15:0] drop_count;

    pipe_out_serializer_if #(.WIDTH(144)) pipe_bus ();
    pipe_out_serializer_if #(.WIDTH(32))  out_bus ();

    // Method 0 -> 1 word, method 1 -> 4 words, method 2 -> 2 words.
    pipe_out_serializer #(
        .METHOD_WIDTH(16),
        .DATA_WIDTH(128),
        .WORD_WIDTH(32),
        .NUM_METHODS(NUM_METHODS),
        .METHOD_WORDS({4'd2, 4'd4, 4'd1})
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .pipe(pipe_bus),
        .out(out_bus),
        .drop_count(drop_count)
    );

    always #5 CLK = ~CLK;

    logic [31:0] exp_q[$];
    logic [31:0] seen_q[$];
    int          seen_cyc[$];
    int          model_drops = 0;
    bit          model_up    = 1'b0;
    int          cyc         = 0;
    int          tests       = 0;
    int          fails       = 0;

    function automatic int model_len(input int method);
        case (method)
            0:       return 1;
            1:       return 4;
            2:       return 2;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_accept(input logic [143:0] msg);
        int method;
        int len;
        method = int'(msg[143:128]);
        if (method < NUM_METHODS) begin
            len = model_len(method);
            exp_q.push_back({msg[143:128], 16'(len)});
            for (int i = 0; i < len; i++) begin
                exp_q.push_back(msg[i*32 +: 32]);
            end
        end else if (model_drops < 65535) begin
            model_drops++;
        end
    endtask

    // Runs 1ns before each rising edge; judges the cycle, then folds in this cycle's handshakes.
    task automatic checkOutput();
        bit want_rdy;
        want_rdy = model_up && ((exp_q.size() == 0) || (exp_q.size() == 1 && out_bus.enq__RDY));
        check("pipe_rdy", 32'(pipe_bus.enq__RDY), 32'(want_rdy));
        check("out_ena", 32'(out_bus.enq__ENA), 32'(out_bus.enq__RDY && (exp_q.size() > 0)));
        if (exp_q.size() > 0) begin
            check("out_word", out_bus.enq_v, exp_q[0]);
        end
        if (out_bus.enq__ENA) begin
            seen_q.push_back(out_bus.enq_v);
            seen_cyc.push_back(cyc);
            if (exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
        end
        check("drop_count", 32'(drop_count), 32'(model_drops));
        if (pipe_bus.enq__ENA && pipe_bus.enq__RDY) begin
            model_accept(pipe_bus.enq_v);
        end
        if (nRST) begin
            model_up = 1'b1;
        end
        cyc++;
    endtask

    task automatic applyStimulus(input bit ordy, input bit want, input logic [143:0] msg, output bit took);
        @(negedge CLK);
        out_bus.enq__RDY  = ordy;
        pipe_bus.enq__ENA = 1'b0;
        #1;
        pipe_bus.enq__ENA = want && pipe_bus.enq__RDY;
        pipe_bus.enq_v    = msg;
        took              = pipe_bus.enq__ENA;
        #3;
        checkOutput();
    endtask

    task automatic idleCycles(input int n);
        bit t;
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b0, '0, t);
        end
    endtask

    task automatic drain(input string name);
        bit t;
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
            applyStimulus(1'b1, 1'b0, '0, t);
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic releaseReset();
        @(negedge CLK);
        nRST              = 1'b1;
        pipe_bus.enq__ENA = 1'b0;
        #4;
        checkOutput();
    endtask

    task automatic assertReset();
        @(negedge CLK);
        pipe_bus.enq__ENA = 1'b0;
        #2;
        nRST = 1'b0;
        #1;
        check("rst_out_ena", 32'(out_bus.enq__ENA), 32'd0);
        check("rst_out_word", out_bus.enq_v, 32'd0);
        check("rst_pipe_rdy", 32'(pipe_bus.enq__RDY), 32'd0);
        check("rst_drops", 32'(drop_count), 32'd0);
        exp_q.delete();
        model_up    = 1'b0;
        model_drops = 0;
    endtask

    initial begin
        bit          took;
        bit          took2;
        int          sent;
        int          r;
        int          method;
        logic [143:0] msgs[2];
        logic [143:0] msg;

        pipe_bus.enq__ENA = 1'b0;
        pipe_bus.enq_v    = '0;
        out_bus.enq__RDY  = 1'b0;

        #1;
        nRST = 1'b0;
        #1;
        check("init_out_ena", 32'(out_bus.enq__ENA), 32'd0);
        check("init_out_word", out_bus.enq_v, 32'd0);
        check("init_pipe_rdy", 32'(pipe_bus.enq__RDY), 32'd0);
        check("init_drops", 32'(drop_count), 32'd0);
        applyStimulus(1'b1, 1'b0, '0, took);
        releaseReset();
        idleCycles(1);

        // Single-word frame from method 0.
        seen_q.delete();
        applyStimulus(1'b1, 1'b1, {16'd0, 96'h0, 32'hDEADBEEF}, took);
        check("t1_took", 32'(took), 32'd1);
        idleCycles(3);
        check("t1_count", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() == 2) begin
            check("t1_hdr", seen_q[0], 32'h0000_0001);
            check("t1_data", seen_q[1], 32'hDEADBEEF);
        end

        // Four-word frame from method 1.
        seen_q.delete();
        seen_cyc.delete();
        applyStimulus(1'b1, 1'b1, {16'd1, 32'h4444, 32'h3333, 32'h2222, 32'h1111}, took);
        idleCycles(6);
        check("t2_count", 32'(seen_q.size()), 32'd5);
        if (seen_q.size() == 5) begin
            check("t2_hdr", seen_q[0], 32'h0001_0004);
            check("t2_w0", seen_q[1], 32'h0000_1111);
            check("t2_w3", seen_q[4], 32'h0000_4444);
            check("t2_span", 32'(seen_cyc[4] - seen_cyc[0]), 32'd4);
        end

        // Second message offered on the final data cycle of the first.
        seen_q.delete();
        seen_cyc.delete();
        applyStimulus(1'b1, 1'b1, {16'd0, 96'h0, 32'hAAAA0001}, took);
        applyStimulus(1'b1, 1'b0, '0, took);
        applyStimulus(1'b1, 1'b1, {16'd0, 96'h0, 32'hAAAA0002}, took2);
        check("t3_took2", 32'(took2), 32'd1);
        idleCycles(3);
        check("t3_count", 32'(seen_q.size()), 32'd4);
        if (seen_q.size() == 4) begin
            check("t3_span", 32'(seen_cyc[3] - seen_cyc[0]), 32'd3);
            check("t3_data_b", seen_q[3], 32'hAAAA0002);
        end

        // Downstream ready toggles every cycle.
        seen_q.delete();
        msgs[0] = {16'd2, 64'h0, 32'h0000_00B2, 32'h0000_00B1};
        msgs[1] = {16'd1, 32'hC4, 32'hC3, 32'hC2, 32'hC1};
        sent    = 0;
        for (int i = 0; i < 24; i++) begin
            applyStimulus(bit'(i % 2), sent < 2, msgs[sent % 2], took);
            if (took) sent++;
        end
        drain("t4_drain");
        check("t4_count", 32'(seen_q.size()), 32'd8);
        if (seen_q.size() == 8) begin
            check("t4_hdr", seen_q[0], 32'h0002_0002);
            check("t4_w1", seen_q[2], 32'h0000_00B2);
            check("t4_last", seen_q[7], 32'h0000_00C4);
        end

        // Unknown method is dropped and counted; the next frame is unaffected.
        seen_q.delete();
        applyStimulus(1'b1, 1'b1, {16'h0005, 128'hF}, took);
        idleCycles(2);
        check("t5_drop_one", 32'(drop_count), 32'd1);
        check("t5_no_words", 32'(seen_q.size()), 32'd0);
        applyStimulus(1'b1, 1'b1, {16'd0, 96'h0, 32'h1234_5678}, took);
        drain("t5_drain");
        idleCycles(1);
        check("t5_count", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() == 2) begin
            check("t5_data", seen_q[1], 32'h1234_5678);
        end

        // Saturation of the drop counter.
        @(posedge CLK);
        #1;
        force dut.drop_count = 16'hFFFF;
        #1;
        release dut.drop_count;
        model_drops = 65535;
        check("t6_forced", 32'(drop_count), 32'h0000_FFFF);
        applyStimulus(1'b1, 1'b1, {16'h0009, 128'h0}, took);
        idleCycles(2);
        check("t6_saturated", 32'(drop_count), 32'h0000_FFFF);

        // Reset in the middle of a payload burst.
        applyStimulus(1'b1, 1'b1, {16'd1, 32'hD4, 32'hD3, 32'hD2, 32'hD1}, took);
        applyStimulus(1'b1, 1'b0, '0, took);
        applyStimulus(1'b1, 1'b0, '0, took);
        assertReset();
        applyStimulus(1'b1, 1'b0, '0, took);
        applyStimulus(1'b1, 1'b0, '0, took);
        releaseReset();
        seen_q.delete();
        applyStimulus(1'b1, 1'b1, {16'd0, 96'h0, 32'hCAFEF00D}, took);
        drain("t7_drain");
        idleCycles(2);
        check("t7_count", 32'(seen_q.size()), 32'd2);
        if (seen_q.size() == 2) begin
            check("t7_hdr", seen_q[0], 32'h0000_0001);
            check("t7_data", seen_q[1], 32'hCAFEF00D);
        end

        // Randomized traffic with backpressure and occasional unknown methods.
        for (int i = 0; i < 400; i++) begin
            r      = $urandom_range(0, 9);
            method = (r < 8) ? (r % 3) : (3 + $urandom_range(0, 100));
            msg    = {16'(method), $urandom, $urandom, $urandom, $urandom};
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, msg, took);
        end
        drain("rand_drain");
        idleCycles(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
